aging_monitor_scheduler: RTL and testbench
==========================================

Name: aging_monitor_scheduler

Overview:
- Multi-channel successor to the single-configuration aging-sensor control.
- Time-multiplexes CHANNEL_COUNT ring-oscillator aging sensors: clears, enables for a fixed window, waits for count settle, samples, compares against a threshold, streams one result per channel.
- Sits between the aging sensor array and the readout/ILA logic. Supports one-shot and continuous sweeps.

Parameters:
- CHANNEL_COUNT, 2, number of aging sensors scheduled (>=1)
- COUNTER_WIDTH, 32, width of sensor counts, threshold and result count
- MEAS_CYCLES, 1000000, reference-clock cycles a sensor stays enabled per measurement (>=1)
- SETTLE_CYCLES, 4, cycles between sensor disable and count sampling (>=1; covers oscillator-domain sync)
- IDLE_CYCLES, 16, gap between sweeps in continuous mode (>=1)

Ports:
- clk  in  1  reference clock
- nreset  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle pulse; begins a sweep when idle
- continuous_i  in  1  1: restart the sweep after IDLE_CYCLES; sampled at sweep end
- abort_i  in  1  terminates any sweep, returns to IDLE
- threshold_i  in  COUNTER_WIDTH  aging threshold; sampled at sweep start
- aged_clear_i  in  1  clears all sticky aged flags
- sensor_clear_o  out  CHANNEL_COUNT  one-hot per-sensor counter clear
- sensor_en_o  out  CHANNEL_COUNT  one-hot per-sensor oscillator enable
- sensor_count_i  in  CHANNEL_COUNT*COUNTER_WIDTH  packed sensor counts; channel k at bits [k*W +: W]
- res_valid_o  out  1  result valid
- res_ready_i  in  1  consumer ready
- res_channel_o  out  $clog2(CHANNEL_COUNT) (min 1)  channel of result
- res_count_o  out  COUNTER_WIDTH  sampled count
- res_aged_o  out  1  count <= threshold
- aged_o  out  CHANNEL_COUNT  sticky per-channel aged flags
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset values: all outputs 0; state IDLE; channel index 0.
- States: IDLE, CLEAR, MEASURE, SETTLE, SAMPLE, REPORT, GAP.
- IDLE: start_i=1 -> CLEAR next cycle; latch threshold_i; channel=0.
- CLEAR: exactly 1 cycle; sensor_clear_o[ch]=1 -> MEASURE.
- MEASURE: sensor_en_o[ch]=1 for exactly MEAS_CYCLES cycles -> SETTLE.
- SETTLE: all enables 0 for SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE: 1 cycle; capture count[ch]; res_aged = (count <= latched threshold), unsigned.
  - If res_aged: set aged_o[ch]; on same-cycle aged_clear_i, the set wins.
  - -> REPORT.
- REPORT: res_valid_o=1; channel/count/aged held stable until res_valid_o && res_ready_i.
  - On handshake: if ch < CHANNEL_COUNT-1, ch++ -> CLEAR.
  - Else: done_o=1 in the handshake cycle; continuous_i=1 -> GAP, else -> IDLE.
- GAP: IDLE_CYCLES cycles -> CLEAR with ch=0; re-latch threshold_i on entry to CLEAR.
- Per-channel latency with res_ready_i held high: 1+MEAS_CYCLES+SETTLE_CYCLES+1 cycles, plus 1 REPORT cycle.
- start_i outside IDLE is ignored.
- abort_i (any state except IDLE, highest priority): -> IDLE next cycle; enables/clears 0; res_valid_o drops; no done_o; aged_o kept.
- Counts equal to all-ones are reported unmodified.
- At most one bit of sensor_en_o / sensor_clear_o is high, never both in the same cycle.
- Asynchronous reset mid-sweep: immediate return to reset values.

Optional Feature:
- Macro AGING_MONITOR_BASELINE_EN.
- Defined: the first SAMPLE of each channel after reset or aged_clear_i stores a per-channel baseline and reports res_aged=0.
  - Later samples: res_aged = (baseline - count) >= threshold, computed only when count < baseline, else 0.
  - aged_clear_i also invalidates the baselines.
- Undefined: absolute comparison as above; no baseline storage.

Decomposition:
- aging_monitor_pkg: state enum, result struct {channel, count, aged}, channel-index width function (min 1).
- Sub-module aging_monitor_timer: loadable down-counter with load value, start, expired pulse; shared by MEASURE, SETTLE and GAP.

Test Plan:
Common parameters: CHANNEL_COUNT=3, MEAS_CYCLES=20, SETTLE_CYCLES=2, IDLE_CYCLES=4.
- One-shot, res_ready_i=1, counts {50,5,7}, threshold 6 -> results ch0/50/0, ch1/5/1, ch2/7/0.
  - aged_o=3'b010; sensor_en_o[k] high exactly 20 cycles each; one done_o pulse; busy_o low afterwards.
- Backpressure: res_ready_i low for 10 cycles in ch1 REPORT -> res_* stable throughout; ch2 CLEAR starts the cycle after the handshake.
- Continuous=1 -> second sweep's ch0 CLEAR exactly 4 cycles after done_o; threshold change mid-sweep takes effect only in the next sweep.
- abort_i during ch1 MEASURE cycle 10 -> IDLE next cycle; sensor_en_o=0; no done_o; start_i re-runs from ch0.
- aged_clear_i in the same cycle as ch1 aged SAMPLE -> aged_o[1]=1; start_i while busy ignored.
- With AGING_MONITOR_BASELINE_EN, threshold 6: ch0 counts 100 then 93 -> aged 0, then 1; count 101 -> aged 0.

Source files
------------

// File: rtl/aging_monitor_pkg.sv
// Shared types for the aging-sensor scheduler: FSM state encoding and the
// channel-index width helper used by the top and its bench.
package aging_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_SAMPLE  = 3'd4,
        ST_REPORT  = 3'd5,
        ST_GAP     = 3'd6
    } state_t;

    // A single sensor still needs a 1-bit channel field on the result stream.
    function automatic int ch_index_width(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/aging_monitor_timer.sv
// Loadable down-counter shared by the MEASURE, SETTLE and GAP phases.
// Loading N makes expired pulse on the N-th cycle after the load edge.
module aging_monitor_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = (count_q == WIDTH'(1));

endmodule

// File: rtl/aging_monitor_scheduler.sv
// Time-multiplexed ring-oscillator aging-sensor scheduler with a valid/ready
// result stream. Optional baseline mode: define AGING_MONITOR_BASELINE_EN.
module aging_monitor_scheduler
    import aging_monitor_pkg::*;
#(
    parameter int CHANNEL_COUNT = 2,
    parameter int COUNTER_WIDTH = 32,
    parameter int MEAS_CYCLES   = 1000000,
    parameter int SETTLE_CYCLES = 4,
    parameter int IDLE_CYCLES   = 16
) (
    input  logic                                     clk,
    input  logic                                     nreset,
    input  logic                                     start_i,
    input  logic                                     continuous_i,
    input  logic                                     abort_i,
    input  logic [COUNTER_WIDTH-1:0]                 threshold_i,
    input  logic                                     aged_clear_i,
    output logic [CHANNEL_COUNT-1:0]                 sensor_clear_o,
    output logic [CHANNEL_COUNT-1:0]                 sensor_en_o,
    input  logic [CHANNEL_COUNT*COUNTER_WIDTH-1:0]   sensor_count_i,
    output logic                                     res_valid_o,
    input  logic                                     res_ready_i,
    output logic [ch_index_width(CHANNEL_COUNT)-1:0] res_channel_o,
    output logic [COUNTER_WIDTH-1:0]                 res_count_o,
    output logic                                     res_aged_o,
    output logic [CHANNEL_COUNT-1:0]                 aged_o,
    output logic                                     busy_o,
    output logic                                     done_o,
    output state_t                                   dbg_state_o
);

    localparam int CH_W = ch_index_width(CHANNEL_COUNT);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNEL_COUNT - 1);
    localparam int T_MAX_A = (MEAS_CYCLES > SETTLE_CYCLES) ? MEAS_CYCLES : SETTLE_CYCLES;
    localparam int T_MAX   = (T_MAX_A > IDLE_CYCLES) ? T_MAX_A : IDLE_CYCLES;
    localparam int TIMER_W = $clog2(T_MAX + 1);

    typedef struct packed {
        logic [CH_W-1:0]          channel;
        logic [COUNTER_WIDTH-1:0] count;
        logic                     aged;
    } result_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [COUNTER_WIDTH-1:0] thr_q, thr_d;
    result_t                  res_q;
    logic [CHANNEL_COUNT-1:0] aged_q, aged_d;
    logic                     timer_start, timer_clear, timer_expired;
    logic [TIMER_W-1:0]       timer_load;
    logic                     sample_en, sample_aged, done;
    logic [COUNTER_WIDTH-1:0] counts [CHANNEL_COUNT];
    logic [COUNTER_WIDTH-1:0] sel_count;

    for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_unpack
        assign counts[k] = sensor_count_i[k*COUNTER_WIDTH +: COUNTER_WIDTH];
    end

    assign sel_count = counts[ch_q];

    aging_monitor_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .nreset     (nreset),
        .start      (timer_start),
        .clear      (timer_clear),
        .load_value (timer_load),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            thr_q   <= '0;
            aged_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            thr_q   <= thr_d;
            aged_q  <= aged_d;
        end
    end

    // Result stream: res_valid_o is high for the whole REPORT state and the
    // channel/count/aged fields are frozen until a cycle with valid && ready.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        thr_d       = thr_q;
        timer_start = 1'b0;
        timer_load  = '0;
        sample_en   = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLEAR;
                    ch_d    = '0;
                    thr_d   = threshold_i;
                end
            end
            ST_CLEAR: begin
                state_d     = ST_MEASURE;
                timer_start = 1'b1;
                timer_load  = TIMER_W'(MEAS_CYCLES);
            end
            ST_MEASURE: begin
                if (timer_expired) begin
                    state_d     = ST_SETTLE;
                    timer_start = 1'b1;
                    timer_load  = TIMER_W'(SETTLE_CYCLES);
                end
            end
            ST_SETTLE: begin
                if (timer_expired) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                sample_en = 1'b1;
                state_d   = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_ready_i) begin
                    if (ch_q != LAST_CH) begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = ST_CLEAR;
                    end else begin
                        done = 1'b1;
                        if (continuous_i) begin
                            state_d     = ST_GAP;
                            timer_start = 1'b1;
                            timer_load  = TIMER_W'(IDLE_CYCLES);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (timer_expired) begin
                    state_d = ST_CLEAR;
                    ch_d    = '0;
                    thr_d   = threshold_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort outranks every transition, including the final handshake.
        if (abort_i && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            ch_d        = '0;
            timer_start = 1'b0;
            sample_en   = 1'b0;
            done        = 1'b0;
        end
    end

    assign timer_clear = abort_i && (state_q != ST_IDLE);

`ifdef AGING_MONITOR_BASELINE_EN
    logic [COUNTER_WIDTH-1:0] baseline_q [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] base_valid_q;

    // First sample after reset/clear only records the baseline.
    always_comb begin
        sample_aged = 1'b0;
        if (base_valid_q[ch_q] && (sel_count < baseline_q[ch_q]))
            sample_aged = ((baseline_q[ch_q] - sel_count) >= thr_q);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            base_valid_q <= '0;
            for (int k = 0; k < CHANNEL_COUNT; k++) baseline_q[k] <= '0;
        end else begin
            if (aged_clear_i) base_valid_q <= '0;
            if (sample_en && !base_valid_q[ch_q]) begin
                baseline_q[ch_q]   <= sel_count;
                base_valid_q[ch_q] <= 1'b1;
            end
        end
    end
`else
    assign sample_aged = (sel_count <= thr_q);
`endif

    always_comb begin
        aged_d = aged_clear_i ? '0 : aged_q;
        if (sample_en && sample_aged) aged_d[ch_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            res_q <= '0;
        end else if (sample_en) begin
            res_q.channel <= ch_q;
            res_q.count   <= sel_count;
            res_q.aged    <= sample_aged;
        end
    end

    assign sensor_clear_o = (state_q == ST_CLEAR)   ? (CHANNEL_COUNT'(1) << ch_q) : '0;
    assign sensor_en_o    = (state_q == ST_MEASURE) ? (CHANNEL_COUNT'(1) << ch_q) : '0;
    assign res_valid_o    = (state_q == ST_REPORT);
    assign res_channel_o  = res_q.channel;
    assign res_count_o    = res_q.count;
    assign res_aged_o     = res_q.aged;
    assign aged_o         = aged_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = done;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_aging_monitor_scheduler.sv
// Directed bench for aging_monitor_scheduler (3 channels, 20/2/4 cycle timing).
module tb_aging_monitor_scheduler;
    import aging_monitor_pkg::*;

    localparam int CC     = 3;
    localparam int W      = 16;
    localparam int MEAS   = 20;
    localparam int SETTLE = 2;
    localparam int IDLE   = 4;
    localparam int CH_W   = 2;
    localparam int RW     = CH_W + W + 1;
    localparam int SWEEP  = CC * (1 + MEAS + SETTLE + 1 + 1);

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            start = 1'b0, continuous = 1'b0, abort = 1'b0;
    logic [W-1:0]    threshold = '0;
    logic            aged_clear = 1'b0;
    logic [CC-1:0]   sensor_clear, sensor_en;
    logic [CC*W-1:0] sensor_count = '0;
    logic            res_valid, res_ready = 1'b1;
    logic [CH_W-1:0] res_channel;
    logic [W-1:0]    res_count;
    logic            res_aged;
    logic [CC-1:0]   aged;
    logic            busy, done;
    state_t          dbg_state;

    aging_monitor_scheduler #(
        .CHANNEL_COUNT(CC), .COUNTER_WIDTH(W), .MEAS_CYCLES(MEAS),
        .SETTLE_CYCLES(SETTLE), .IDLE_CYCLES(IDLE)
    ) dut (
        .clk(clk), .nreset(nreset), .start_i(start), .continuous_i(continuous),
        .abort_i(abort), .threshold_i(threshold), .aged_clear_i(aged_clear),
        .sensor_clear_o(sensor_clear), .sensor_en_o(sensor_en),
        .sensor_count_i(sensor_count), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_channel_o(res_channel), .res_count_o(res_count), .res_aged_o(res_aged),
        .aged_o(aged), .busy_o(busy), .done_o(done), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int n_vec = 0, n_err = 0;
    logic [RW-1:0] exp_q[$];
    int en_cnt[CC];
    int clear_cyc[CC];
    int hs_cyc[CC];
    int done_cnt = 0, viol = 0;
    int sweep_cyc[$];
    int done_cyc[$];
    logic prev_valid = 1'b0, prev_hs = 1'b0;
    logic [RW-1:0] prev_res = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial for (int k = 0; k < CC; k++) begin
        en_cnt[k] = 0; clear_cyc[k] = 0; hs_cyc[k] = 0;
    end

    // monitor: samples on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (!nreset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            for (int k = 0; k < CC; k++) begin
                if (sensor_en[k]) en_cnt[k]++;
                if (sensor_clear[k]) clear_cyc[k] = cyc;
            end
            if ($countones(sensor_en) > 1 || $countones(sensor_clear) > 1 ||
                (|sensor_en && |sensor_clear)) viol++;
            if (sensor_clear[0]) sweep_cyc.push_back(cyc);
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            if (res_valid && prev_valid && !prev_hs)
                check("hold", {res_channel, res_count, res_aged}, prev_res);
            if (res_valid && res_ready) begin
                hs_cyc[res_channel] = cyc;
                if (exp_q.size() == 0) check("result_count", exp_q.size(), 1);
                else check("result", {res_channel, res_count, res_aged}, exp_q.pop_front());
            end
            prev_valid = res_valid;
            prev_hs    = res_valid && res_ready;
            prev_res   = {res_channel, res_count, res_aged};
        end
    end

    // driver tasks
    task automatic set_counts(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2);
        sensor_count = {c2, c1, c0};
    endtask

    task automatic push_exp(input logic [CH_W-1:0] ch, input logic [W-1:0] cnt, input logic a);
        exp_q.push_back({ch, cnt, a});
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_aged_clear();
        @(negedge clk) aged_clear = 1'b1;
        @(negedge clk) aged_clear = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic wait_clear(input int k);
        int t = 0;
        @(negedge clk);
        while (!sensor_clear[k] && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (!sensor_clear[k]) check("clear_timeout", sensor_clear[k], 1);
    endtask

    task automatic wait_state(input state_t s);
        int t = 0;
        while (dbg_state != s && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (dbg_state != s) check("state_timeout", dbg_state, s);
    endtask

    task automatic check_sweep_len(input string tag, input int s_idx, input int d_idx, input int len);
        if (sweep_cyc.size() > s_idx && done_cyc.size() > d_idx)
            check(tag, done_cyc[d_idx] - sweep_cyc[s_idx], len);
        else
            check({tag, "_missing"}, done_cyc.size(), d_idx + 1);
    endtask

    task automatic run_sweep(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2,
                             input logic [W-1:0] thr, input logic a0, input logic a1, input logic a2);
        int d0;
        d0 = done_cnt;
        set_counts(c0, c1, c2);
        threshold = thr;
        push_exp(2'd0, c0, a0);
        push_exp(2'd1, c1, a1);
        push_exp(2'd2, c2, a2);
        pulse_start();
        wait_done(d0 + 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int e0[CC];
        int d0, s_idx, dd_idx;

        // reset values
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_outs", {sensor_en, sensor_clear, res_valid, done, aged}, 0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_state", dbg_state, ST_IDLE);
        check("post_reset_res", {res_channel, res_count, res_aged}, 0);

`ifdef AGING_MONITOR_BASELINE_EN
        // baseline mode: first sample stores baseline, later ones compare drift
        run_sweep(16'd100, 16'd50, 16'd50, 16'd6, 1'b0, 1'b0, 1'b0);
        check("bl_aged_first", aged, 3'b000);
        run_sweep(16'd93, 16'd50, 16'd51, 16'd6, 1'b1, 1'b0, 1'b0);
        check("bl_aged_second", aged, 3'b001);
        run_sweep(16'd101, 16'd44, 16'd50, 16'd6, 1'b0, 1'b1, 1'b0);
        check("bl_aged_third", aged, 3'b011);
`else
        // one-shot sweep, ready held high
        for (int k = 0; k < CC; k++) e0[k] = en_cnt[k];
        d0 = done_cnt; s_idx = sweep_cyc.size(); dd_idx = done_cyc.size();
        run_sweep(16'd50, 16'd5, 16'd7, 16'd6, 1'b0, 1'b1, 1'b0);
        check("oneshot_aged", aged, 3'b010);
        check("oneshot_busy", busy, 0);
        check("oneshot_done_pulses", done_cnt - d0, 1);
        for (int k = 0; k < CC; k++) check("meas_window", en_cnt[k] - e0[k], MEAS);
        check_sweep_len("oneshot_latency", s_idx, dd_idx, SWEEP - 1);

        // backpressure on ch1, aged_clear racing ch1's aged sample, start while busy
        pulse_aged_clear();
        check("aged_cleared", aged, 0);
        d0 = done_cnt; s_idx = sweep_cyc.size(); dd_idx = done_cyc.size();
        set_counts(16'd1, 16'd2, 16'd3);
        threshold = 16'd2;
        push_exp(2'd0, 16'd1, 1'b1);
        push_exp(2'd1, 16'd2, 1'b1);
        push_exp(2'd2, 16'd3, 1'b0);
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_clear(1);
        wait_state(ST_SAMPLE);
        res_ready  = 1'b0;
        aged_clear = 1'b1;
        @(negedge clk) aged_clear = 1'b0;
        check("clear_vs_set", aged, 3'b010);
        repeat (10) @(negedge clk);
        check("stalled_valid", res_valid, 1);
        res_ready = 1'b1;
        wait_done(d0 + 1);
        repeat (30) @(negedge clk);
        check("bp_next_clear", clear_cyc[2] - hs_cyc[1], 1);
        check("bp_done_pulses", done_cnt - d0, 1);
        check("bp_busy", busy, 0);
        check("bp_aged", aged, 3'b010);
        check_sweep_len("bp_latency", s_idx, dd_idx, SWEEP - 1 + 10);

        // continuous mode with a mid-sweep threshold change; all-ones count
        pulse_aged_clear();
        d0 = done_cnt; s_idx = sweep_cyc.size(); dd_idx = done_cyc.size();
        set_counts(16'd10, 16'd20, 16'hFFFF);
        threshold  = 16'd15;
        continuous = 1'b1;
        push_exp(2'd0, 16'd10, 1'b1);
        push_exp(2'd1, 16'd20, 1'b0);
        push_exp(2'd2, 16'hFFFF, 1'b0);
        pulse_start();
        wait_clear(1);
        threshold = 16'd25;
        wait_done(d0 + 1);
        continuous = 1'b0;
        push_exp(2'd0, 16'd10, 1'b1);
        push_exp(2'd1, 16'd20, 1'b1);
        push_exp(2'd2, 16'hFFFF, 1'b0);
        wait_done(d0 + 2);
        repeat (3) @(negedge clk);
        if (sweep_cyc.size() > s_idx + 1 && done_cyc.size() > dd_idx)
            check("gap_len", sweep_cyc[s_idx + 1] - done_cyc[dd_idx], IDLE + 1);
        else
            check("gap_missing", sweep_cyc.size(), s_idx + 2);
        check("cont_done_pulses", done_cnt - d0, 2);
        check("cont_aged", aged, 3'b011);
        check("cont_busy", busy, 0);

        // abort in ch1 MEASURE cycle 10, then a full rerun from ch0
        d0 = done_cnt;
        set_counts(16'd100, 16'd100, 16'd100);
        threshold = 16'd0;
        push_exp(2'd0, 16'd100, 1'b0);
        pulse_start();
        wait_clear(1);
        e0[1] = en_cnt[1];
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_outs", {sensor_en, sensor_clear, res_valid, busy}, 0);
        repeat (3) @(negedge clk);
        check("abort_meas_cycles", en_cnt[1] - e0[1], 10);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_aged_kept", aged, 3'b011);
        check("abort_pending", exp_q.size(), 0);
        s_idx = sweep_cyc.size(); dd_idx = done_cyc.size();
        run_sweep(16'd0, 16'd100, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        check("rerun_aged", aged, 3'b111);
        check_sweep_len("rerun_latency", s_idx, dd_idx, SWEEP - 1);

        // asynchronous reset mid-sweep
        pulse_start();
        repeat (5) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("async_reset_outs", {busy, sensor_en, sensor_clear, aged}, 0);
        @(negedge clk) nreset = 1'b1;
        repeat (2) @(negedge clk);
        check("async_reset_state", dbg_state, ST_IDLE);
`endif

        repeat (2) @(negedge clk);
        check("onehot_violations", viol, 0);
        check("leftover_expected", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
